// File: rtl/ctrl_fc_sched_pkg.sv
// Shared types for the FC layer scheduler: FSM state encoding and the
// start/valid/stop control word that travels along the MAC pipeline.
package ctrl_fc_sched_pkg;

    localparam int CORE_DEF   = 8;
    localparam int LWIDTH_DEF = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        GAP,
        DRAIN,
        DONE
    } sched_state;

    typedef struct packed {
        logic start;
        logic valid;
        logic stop;
    } ctrl_reg;

endpackage

// File: rtl/ctrl_fc_sched_addr_gen.sv
// Group/input counters and memory address registers for one FC layer.
// The weight address only ever increments, so no multiplier is needed.
module sched_addr_gen #(
    parameter int CORE    = 8,
    parameter int LWIDTH  = 10,
    parameter int IMGSIZE = 12,
    parameter int WSIZE   = 12,
    parameter int LANEW   = $clog2(CORE + 1)
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               load_i,
    input  logic               beat_i,
    input  logic               gap_i,
    input  logic [LWIDTH-1:0]  total_in_i,
    input  logic [LWIDTH-1:0]  total_out_i,
    input  logic [IMGSIZE-1:0] in_base_i,
    output logic [IMGSIZE-1:0] in_addr_o,
    output logic [WSIZE-1:0]   w_addr_o,
    output logic [LANEW-1:0]   lanes_o,
    output logic               first_beat_o,
    output logic               last_beat_o,
    output logic               last_group_o,
    output logic [LWIDTH-1:0]  groups_o
);

    logic [LWIDTH-1:0]  n_in_q;
    logic [LWIDTH-1:0]  i_q;
    logic [LWIDTH-1:0]  g_q;
    logic [LWIDTH-1:0]  groups_q;
    logic [LWIDTH-1:0]  rem_q;
    logic [IMGSIZE-1:0] base_q;
    logic [IMGSIZE-1:0] in_addr_q;
    logic [WSIZE-1:0]   w_addr_q;
    logic [LWIDTH:0]    out_round;
    logic [LWIDTH-1:0]  groups_d;

    // One extra bit so N_out near 2^LWIDTH does not overflow the rounding.
    assign out_round = {1'b0, total_out_i} + (LWIDTH+1)'(CORE - 1);
    assign groups_d  = LWIDTH'(out_round / (LWIDTH+1)'(CORE));

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            n_in_q    <= '0;
            i_q       <= '0;
            g_q       <= '0;
            groups_q  <= '0;
            rem_q     <= '0;
            base_q    <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
        end else if (load_i) begin
            n_in_q    <= total_in_i;
            base_q    <= in_base_i;
            groups_q  <= groups_d;
            rem_q     <= total_out_i;
            i_q       <= '0;
            g_q       <= '0;
            in_addr_q <= in_base_i;
            w_addr_q  <= '0;
        end else if (beat_i) begin
            i_q       <= i_q + 1'b1;
            in_addr_q <= in_addr_q + 1'b1;
            w_addr_q  <= w_addr_q + 1'b1;
        end else if (gap_i) begin
            // w_addr already sits at (g+1)*N_in after the last beat.
            i_q       <= '0;
            in_addr_q <= base_q;
            g_q       <= g_q + 1'b1;
            if (!last_group_o) begin
                rem_q <= rem_q - LWIDTH'(CORE);
            end
        end
    end

    assign in_addr_o    = in_addr_q;
    assign w_addr_o     = w_addr_q;
    assign lanes_o      = (rem_q >= LWIDTH'(CORE)) ? LANEW'(CORE) : LANEW'(rem_q);
    assign first_beat_o = (i_q == '0);
    assign last_beat_o  = (i_q == n_in_q - 1'b1);
    assign last_group_o = (g_q == groups_q - 1'b1);
    assign groups_o     = groups_q;

endmodule

// File: rtl/ctrl_fc_sched.sv
// FC layer scheduler: streams a layer through the pipeline one CORE-wide
// group at a time and acks once every group's stop returns from the tail.
module ctrl_fc_sched
    import ctrl_fc_sched_pkg::*;
#(
    parameter int CORE    = CORE_DEF,
    parameter int LWIDTH  = LWIDTH_DEF,
    parameter int IMGSIZE = 12,
    parameter int WSIZE   = 12
) (
    input  logic                       clk,
    input  logic                       xrst,
    input  logic                       req,
    input  logic [LWIDTH-1:0]          total_in,
    input  logic [LWIDTH-1:0]          total_out,
    input  logic [IMGSIZE-1:0]         in_base,
    input  logic                       relu_en,
    input  ctrl_reg                    in_tail,
    output ctrl_reg                    out_ctrl,
    output logic [IMGSIZE-1:0]         mem_in_addr,
    output logic [WSIZE-1:0]           mem_w_addr,
    output logic [$clog2(CORE+1)-1:0]  out_lanes,
    output logic                       relu_bypass,
    output logic                       busy,
    output logic                       ack
);

    sched_state        state_q, state_d;
    logic [LWIDTH-1:0] tail_q, tail_d;
    logic              relu_bypass_q;
    logic              load, beat, gap;
    logic              first_beat, last_beat, last_group;
    logic [LWIDTH-1:0] groups;

    sched_addr_gen #(
        .CORE    (CORE),
        .LWIDTH  (LWIDTH),
        .IMGSIZE (IMGSIZE),
        .WSIZE   (WSIZE),
        .LANEW   ($clog2(CORE + 1))
    ) u_addr_gen (
        .clk          (clk),
        .xrst         (xrst),
        .load_i       (load),
        .beat_i       (beat),
        .gap_i        (gap),
        .total_in_i   (total_in),
        .total_out_i  (total_out),
        .in_base_i    (in_base),
        .in_addr_o    (mem_in_addr),
        .w_addr_o     (mem_w_addr),
        .lanes_o      (out_lanes),
        .first_beat_o (first_beat),
        .last_beat_o  (last_beat),
        .last_group_o (last_group),
        .groups_o     (groups)
    );

    // Tail stops are counted in every busy state, so one landing on the
    // GAP->DRAIN edge is not lost.
    always_comb begin
        tail_d = tail_q;
        if (state_q == LOAD) begin
            tail_d = '0;
        end else if (state_q != IDLE && in_tail.stop) begin
            tail_d = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q       <= IDLE;
            tail_q        <= '0;
            relu_bypass_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
            if (state_q == LOAD) begin
                relu_bypass_q <= !relu_en;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        out_ctrl = '0;
        busy     = (state_q != IDLE);
        ack      = 1'b0;
        load     = 1'b0;
        beat     = 1'b0;
        gap      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) state_d = LOAD;
            end
            LOAD: begin
                load    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                out_ctrl.valid = 1'b1;
                out_ctrl.start = first_beat;
                beat           = 1'b1;
                if (last_beat) state_d = GAP;
            end
            GAP: begin
                out_ctrl.stop = 1'b1;
                gap           = 1'b1;
                state_d       = last_group ? DRAIN : RUN;
            end
            DRAIN: begin
                // Look at the next count so ack follows the last tail stop by one cycle.
                if (tail_d >= groups) state_d = DONE;
            end
            DONE: begin
                ack     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign relu_bypass = relu_bypass_q;

endmodule
